// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
package alu_seq_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int INSTR_W = 16;

    // Instruction field positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 14;
    localparam int RD_MSB  = 13;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 2;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        OP_LDI = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_AND = 2'b11
    } opcode_t;

    // ALUControl encodings understood by the datapath
    localparam logic [1:0] ALU_AND    = 2'b00;
    localparam logic [1:0] ALU_PASS_B = 2'b01;
    localparam logic [1:0] ALU_ADD    = 2'b10;
    localparam logic [1:0] ALU_SUB    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Decoded datapath controls for one instruction
    typedef struct packed {
        logic [ADDR_W-1:0] ra1;
        logic [ADDR_W-1:0] ra2;
        logic [ADDR_W-1:0] wa;
        logic              alu_src;
        logic [1:0]        alu_control;
        logic [DATA_W-1:0] ext_data;
    } ctrl_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: instruction word -> datapath controls.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output ctrl_t              ctrl
);

    opcode_t op;

    // Map opcode and register fields onto the datapath control bundle
    always_comb begin
        op               = opcode_t'(instr[OP_MSB:OP_LSB]);
        ctrl             = '0;
        ctrl.wa          = instr[RD_MSB:RD_LSB];
        ctrl.ra1         = instr[RS1_MSB:RS1_LSB];
        ctrl.ra2         = instr[RS2_MSB:RS2_LSB];
        case (op)
            OP_LDI: begin
                // Immediate load: register reads are unused, keep them at 0
                ctrl.ra1         = '0;
                ctrl.ra2         = '0;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_PASS_B;
                ctrl.ext_data    = instr[IMM_MSB:IMM_LSB];
            end
            OP_ADD:  ctrl.alu_control = ALU_ADD;
            OP_SUB:  ctrl.alu_control = ALU_SUB;
            default: ctrl.alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/reg_file_alu.sv
// 16 x 8-bit register file with a two-operand ALU (combinational result).
module reg_file_alu
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic [ADDR_W-1:0] WA,
    input  logic              RegWrite,
    input  logic              ALUSrc,
    input  logic [1:0]        ALUControl,
    input  logic [DATA_W-1:0] external_data_in,
    output logic [DATA_W-1:0] ALUResult
);

    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // Register write-back of the ALU result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (RegWrite) begin
            regs[WA] <= ALUResult;
        end
    end

    // Operand select and ALU operation
    always_comb begin
        op_a = regs[RA1];
        op_b = ALUSrc ? external_data_in : regs[RA2];
        case (ALUControl)
            ALU_AND:    ALUResult = op_a & op_b;
            ALU_PASS_B: ALUResult = op_b;
            ALU_ADD:    ALUResult = op_a + op_b;
            default:    ALUResult = op_a - op_b;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer driving the register-file/ALU datapath.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid holds its payload until that edge, ready may be low at will.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [ADDR_W-1:0]  RA1,
    output logic [ADDR_W-1:0]  RA2,
    output logic [ADDR_W-1:0]  WA,
    output logic               RegWrite,
    output logic               ALUSrc,
    output logic [1:0]         ALUControl,
    output logic [DATA_W-1:0]  external_data_in,
    input  logic [DATA_W-1:0]  ALUResult,
    output logic [DATA_W-1:0]  result_data,
    output logic               result_zero,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [7:0]         instr_count,
    output state_t             fsm_state
);

    state_t state_q;
    state_t state_d;
    logic   accept;
    logic   retire;
    ctrl_t  dec_ctrl;
    ctrl_t  ctrl_q;

    alu_seq_decode u_decode (
        .instr (instr),
        .ctrl  (dec_ctrl)
    );

    // Ready only in IDLE, and forced low while reset is held
    assign instr_ready = (state_q == ST_IDLE) && !reset;
    assign fsm_state   = state_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic plus the two handshake strobes
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid && instr_ready) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (result_ready) begin
                    retire  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Controls are latched at accept and held until the next accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       ctrl_q <= '0;
        else if (accept) ctrl_q <= dec_ctrl;
    end

    assign RA1              = ctrl_q.ra1;
    assign RA2              = ctrl_q.ra2;
    assign WA               = ctrl_q.wa;
    assign ALUSrc           = ctrl_q.alu_src;
    assign ALUControl       = ctrl_q.alu_control;
    assign external_data_in = ctrl_q.ext_data;

    // Write enable is high exactly for the WRITE cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) RegWrite <= 1'b0;
        else       RegWrite <= (state_q == ST_EXEC);
    end

    // Capture the ALU output on the write-back edge and hold it until consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_data  <= '0;
            result_zero  <= 1'b1;
            result_valid <= 1'b0;
        end else if (state_q == ST_WRITE) begin
            result_data  <= ALUResult;
            result_zero  <= (ALUResult == '0);
            result_valid <= 1'b1;
        end else if (retire) begin
            result_valid <= 1'b0;
        end
    end

    // Retired-instruction counter, wraps naturally at 8 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       instr_count <= '0;
        else if (retire) instr_count <= instr_count + 8'd1;
    end

endmodule
